// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V core front end: fetch FSM encoding and
// architectural constants.
package riscv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INSN         = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/pc_reg.sv
// Fetch program counter: word-aligned redirect load and sequential +4 advance.
module pc_reg #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:2] redirect_pc_i,
    input  logic            advance_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_next_o
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;

    // Redirect beats the sequential advance; the add wraps modulo 2^XLEN.
    always_comb begin
        pc_d = pc_q;
        if (redirect_valid_i) begin
            pc_d = {redirect_pc_i, 2'b00};
        end else if (advance_i) begin
            pc_d = pc_q + XLEN'(4);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o      = pc_q;
    assign pc_next_o = pc_d;

endmodule

// File: rtl/fetch_unit.sv
// Multi-cycle instruction fetch: one outstanding memory request, redirect
// handling with a single discard flag, valid/ready hand-off to decode.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst_out,
    output logic [XLEN-1:0] pc_out,
    output logic            fetch_misaligned
);

    fetch_state_t    state_q;
    logic            disc_q;
    logic [XLEN-1:0] imem_addr_q;
    logic [31:0]     inst_out_q;
    logic [XLEN-1:0] pc_out_q;
    logic            misaligned_q;

    logic [XLEN-1:0] pc_fetch;
    logic [XLEN-1:0] pc_next;
    logic            advance;

    assign advance = (state_q == WAIT) && imem_rvalid && !disc_q;

    pc_reg #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk              (clk),
        .reset            (reset),
        .redirect_valid_i (redirect_valid),
        .redirect_pc_i    (redirect_pc[XLEN-1:2]),
        .advance_i        (advance),
        .pc_o             (pc_fetch),
        .pc_next_o        (pc_next)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            disc_q       <= 1'b0;
            imem_addr_q  <= RESET_PC;
            inst_out_q   <= NOP_INSN;
            pc_out_q     <= RESET_PC;
            misaligned_q <= 1'b0;
        end else begin
            misaligned_q <= redirect_valid && (redirect_pc[1:0] != 2'b00);
            case (state_q)
                IDLE: begin
                    state_q     <= REQ;
                    imem_addr_q <= pc_next;
                end
                REQ: begin
                    // The issued address holds until accepted; a redirect only
                    // marks the eventual response stale.
                    if (redirect_valid) disc_q <= 1'b1;
                    if (imem_ready) state_q <= WAIT;
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        if (disc_q || redirect_valid) begin
                            disc_q      <= 1'b0;
                            state_q     <= REQ;
                            imem_addr_q <= pc_next;
                        end else begin
                            inst_out_q <= imem_rdata;
                            pc_out_q   <= pc_fetch;
                            state_q    <= HOLD;
                        end
                    end else if (redirect_valid) begin
                        disc_q <= 1'b1;
                    end
                end
                HOLD: begin
                    if (redirect_valid || inst_ready) begin
                        state_q     <= REQ;
                        imem_addr_q <= pc_next;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign imem_req         = (state_q == REQ);
    assign inst_valid       = (state_q == HOLD);
    assign imem_addr        = imem_addr_q;
    assign inst_out         = inst_out_q;
    assign pc_out           = pc_out_q;
    assign fetch_misaligned = misaligned_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory and decode are driven step by step
// with hand-computed expectations.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic [31:0] pc_out;
    logic        fetch_misaligned;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fetch_unit #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_ready       (imem_ready),
        .imem_rvalid      (imem_rvalid),
        .imem_rdata       (imem_rdata),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .inst_valid       (inst_valid),
        .inst_ready       (inst_ready),
        .inst_out         (inst_out),
        .pc_out           (pc_out),
        .fetch_misaligned (fetch_misaligned)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs change and outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, ".req"},   {31'd0, imem_req},         32'd0);
        chk({tag, ".addr"},  imem_addr,                 32'h0000_0000);
        chk({tag, ".valid"}, {31'd0, inst_valid},       32'd0);
        chk({tag, ".inst"},  inst_out,                  32'h0000_0013);
        chk({tag, ".pc"},    pc_out,                    32'h0000_0000);
        chk({tag, ".mis"},   {31'd0, fetch_misaligned}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b0;
        imem_ready     = 1'b1;
        imem_rvalid    = 1'b0;
        imem_rdata     = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_ready     = 1'b0;
        repeat (3) tick();
        chk_reset_values("rst");

        // Reset release, best-case latency
        reset = 1'b1;
        tick();
        chk("t1.req", {31'd0, imem_req}, 32'd1);
        chk("t1.addr", imem_addr, 32'h0000_0000);
        tick();
        chk("t1.wait_req", {31'd0, imem_req}, 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0050_0093;
        tick();
        imem_rvalid = 1'b0;
        chk("t1.valid", {31'd0, inst_valid}, 32'd1);
        chk("t1.inst", inst_out, 32'h0050_0093);
        chk("t1.pc", pc_out, 32'h0000_0000);

        // Decode stalls five cycles in HOLD
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t2.valid", {31'd0, inst_valid}, 32'd1);
            chk("t2.req", {31'd0, imem_req}, 32'd0);
            chk("t2.inst", inst_out, 32'h0050_0093);
            chk("t2.pc", pc_out, 32'h0000_0000);
        end
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        chk("t2.next_valid", {31'd0, inst_valid}, 32'd0);
        chk("t2.next_req", {31'd0, imem_req}, 32'd1);
        chk("t2.next_addr", imem_addr, 32'h0000_0004);

        // Redirect during WAIT, response arrives later
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        tick();
        redirect_valid = 1'b0;
        chk("t3.mis", {31'd0, fetch_misaligned}, 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        tick();
        imem_rvalid = 1'b0;
        chk("t3.valid", {31'd0, inst_valid}, 32'd0);
        chk("t3.req", {31'd0, imem_req}, 32'd1);
        chk("t3.addr", imem_addr, 32'h0000_0100);

        // Redirect in the same cycle as the response
        tick();
        imem_rvalid    = 1'b1;
        imem_rdata     = 32'h1111_1111;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0040;
        tick();
        imem_rvalid    = 1'b0;
        redirect_valid = 1'b0;
        chk("t4.valid", {31'd0, inst_valid}, 32'd0);
        chk("t4.req", {31'd0, imem_req}, 32'd1);
        chk("t4.addr", imem_addr, 32'h0000_0040);

        // Memory stalls four cycles; misaligned redirect in cycle 2
        imem_ready = 1'b0;
        tick();
        chk("t5.c1_addr", imem_addr, 32'h0000_0040);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0202;
        tick();
        redirect_valid = 1'b0;
        chk("t5.c2_addr", imem_addr, 32'h0000_0040);
        chk("t5.mis_pulse", {31'd0, fetch_misaligned}, 32'd1);
        tick();
        chk("t5.c3_addr", imem_addr, 32'h0000_0040);
        chk("t5.mis_clear", {31'd0, fetch_misaligned}, 32'd0);
        tick();
        chk("t5.c4_req", {31'd0, imem_req}, 32'd1);
        chk("t5.c4_addr", imem_addr, 32'h0000_0040);
        imem_ready = 1'b1;
        tick();
        chk("t5.wait_req", {31'd0, imem_req}, 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h2222_2222;
        tick();
        imem_rvalid = 1'b0;
        chk("t5.valid", {31'd0, inst_valid}, 32'd0);
        chk("t5.addr", imem_addr, 32'h0000_0200);

        // Redirect on the acceptance cycle, then fetch at the top of memory
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h3333_3333;
        tick();
        imem_rvalid = 1'b0;
        chk("t6.drop_valid", {31'd0, inst_valid}, 32'd0);
        chk("t6.addr", imem_addr, 32'hFFFF_FFFC);
        tick();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h1234_5678;
        tick();
        imem_rvalid = 1'b0;
        chk("t6.valid", {31'd0, inst_valid}, 32'd1);
        chk("t6.inst", inst_out, 32'h1234_5678);
        chk("t6.pc", pc_out, 32'hFFFF_FFFC);
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        chk("t6.wrap_addr", imem_addr, 32'h0000_0000);

        // Redirect while holding an instruction
        tick();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h4444_4444;
        tick();
        imem_rvalid = 1'b0;
        chk("t7.pc", pc_out, 32'h0000_0000);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0080;
        tick();
        redirect_valid = 1'b0;
        chk("t7.valid", {31'd0, inst_valid}, 32'd0);
        chk("t7.addr", imem_addr, 32'h0000_0080);

        // Reset asserted mid-WAIT
        tick();
        chk("t8.wait_req", {31'd0, imem_req}, 32'd0);
        reset = 1'b0;
        tick();
        chk_reset_values("t8");
        reset = 1'b1;
        tick();
        chk("t8.req", {31'd0, imem_req}, 32'd1);
        chk("t8.addr", imem_addr, 32'h0000_0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Multi-cycle instruction fetch stage for the sequential RISC-V core: owns the program counter, issues one request at a time to instruction memory, and hands the returned instruction plus its PC to decode over a valid/ready handshake. Taken branches from execute arrive as a redirect that discards any stale fetch and restarts at the target. It replaces the fixed-latency fetch path so the core tolerates instruction memory with variable latency.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, first fetch address after reset; must be 4-byte aligned.
- `XLEN`, 32, address/data width; only 32 is supported.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-low; sampled on the `clk` rising edge.
- `imem_req`  out  1  fetch request valid.
- `imem_addr`  out  XLEN  word-aligned fetch address.
- `imem_ready`  in  1  memory accepts the request this cycle when `imem_req & imem_ready`.
- `imem_rvalid`  in  1  response valid; exactly one response per accepted request, no earlier than the cycle after acceptance.
- `imem_rdata`  in  32  instruction word.
- `redirect_valid`  in  1  one-cycle pulse: branch taken, restart fetch.
- `redirect_pc`  in  XLEN  redirect target.
- `inst_valid`  out  1  instruction available to decode.
- `inst_ready`  in  1  decode consumes when `inst_valid & inst_ready`.
- `inst_out`  out  32  instruction word.
- `pc_out`  out  XLEN  PC of `inst_out`.
- `fetch_misaligned`  out  1  one-cycle pulse: redirect target had nonzero bits [1:0].

## Operation
- FSM states: IDLE, REQ, WAIT, HOLD.
- IDLE: entered on reset; unconditionally moves to REQ next cycle.
- REQ: `imem_req`=1, `imem_addr`=fetch PC. `imem_addr` stays stable until accepted. On acceptance -> WAIT.
- WAIT: `imem_req`=0. On `imem_rvalid`: if discard flag clear, capture `imem_rdata` into `inst_out` and the fetch PC into `pc_out`, go to HOLD, advance fetch PC by 4; if discard flag set, drop the response, clear the flag, go to REQ.
- HOLD: `inst_valid`=1, outputs stable. On `inst_valid & inst_ready` -> REQ.
- Redirect, applies in every state. The fetch PC becomes `{redirect_pc[XLEN-1:2],2'b00}`. When bits [1:0] are nonzero, pulse `fetch_misaligned` the following cycle.
  - In REQ not accepted: request stays at the old address until accepted, and the discard flag is set.
  - In REQ on the acceptance cycle: discard flag set.
  - In WAIT: discard flag set. If `imem_rvalid` arrives in the same cycle, that response is dropped and the FSM goes straight to REQ.
  - In HOLD: `inst_valid` drops the next cycle and the FSM goes to REQ. A handshake in the same cycle still counts as consumed.
  - In IDLE: overrides `RESET_PC`.
  - Multiple redirects before the response drains: the last one wins. The flag is a single bit, which is sufficient because at most one request is outstanding.
- PC arithmetic is modulo 2^XLEN; 0xFFFF_FFFC + 4 wraps to 0.

## Timing
- Reset values: `imem_req`=0, `imem_addr`=`RESET_PC`, `inst_valid`=0, `inst_out`=32'h0000_0013 (NOP), `pc_out`=`RESET_PC`, `fetch_misaligned`=0, state IDLE, discard flag 0.
- Reset asserted mid-operation abandons everything. Any later `imem_rvalid` for a pre-reset request is the environment's responsibility; the bench must not generate one.
- Best case with `imem_ready`=1 and `imem_rvalid` one cycle after acceptance:
  - `imem_req` high 1 cycle after reset deasserts.
  - `inst_valid` high 3 cycles after reset deasserts (IDLE, REQ, WAIT, HOLD).
- Steady-state throughput: one instruction per 3 cycles (REQ, WAIT, HOLD) with `inst_ready`=1.
- All outputs are registered except `imem_req`/`inst_valid`, which decode from state registers only. No combinational path from inputs to outputs.

## Structure
- Shared `riscv_pkg`: `fetch_state_t` enum, `NOP_INSN` constant (32'h0000_0013), `RESET_PC_DEFAULT`.
- One sub-module: `pc_reg`, which holds the fetch PC and performs the +4 increment and redirect alignment. FSM and output registers stay in `fetch_unit`.

## Test plan
- Reset release with `imem_ready`=1 and rvalid latency 1, returning 0x00500093 -> `imem_addr`=0x0 in REQ; `inst_valid` on cycle 3 with `inst_out`=0x00500093 and `pc_out`=0x0; next request at 0x4.
- `inst_ready` held low 5 cycles in HOLD -> `inst_out`/`pc_out` stable, no `imem_req`. Raising `inst_ready` -> REQ at PC+4.
- `redirect_valid` with target 0x100 during WAIT, then response arrives -> response dropped, `inst_valid` stays 0, next `imem_addr`=0x100.
- `redirect_valid` in the same cycle as `imem_rvalid` (target 0x40) -> no `inst_valid`; next request at 0x40.
- `imem_ready` low 4 cycles in REQ, with a redirect to 0x202 in cycle 2 -> `imem_addr` holds the old value until accepted; old response dropped; `fetch_misaligned` pulses once; next request at 0x200.
- Fetch at 0xFFFF_FFFC completes -> next `imem_addr`=0x0000_0000; reset held low mid-WAIT -> all outputs return to their reset values.
